// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep slice-serial adder/subtractor with valid/ready handshake.
// Define PIPELINED_ADDER_SAT_EN to saturate sum on signed overflow.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam int NP = (STAGES > 1) ? STAGES - 1 : 1;
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] a_q [NP];
  logic [WIDTH-1:0] b_q [NP];
  logic             ov_q;
  logic             v_d [STAGES];
  logic             c_i [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] r_i [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic [WIDTH-1:0] s_d;
  logic             ov_d;
  logic             en;
  always_comb begin
    en     = !(v_q[L] && !out_ready);
    v_d[0] = in_valid;
    a_d[0] = a;
    b_d[0] = sub ? ~b : b;
    c_i[0] = sub | cin;
    r_i[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      r_i[k] = r_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r_d[k] = r_i[k];
      {c_d[k], r_d[k][k*SW +: SW]} = {1'b0, a_d[k][k*SW +: SW]} + {1'b0, b_d[k][k*SW +: SW]}
                                     + {{SW{1'b0}}, c_i[k]};
    end
    ov_d = (a_d[L][WIDTH-1] == b_d[L][WIDTH-1]) && (r_d[L][WIDTH-1] != a_d[L][WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    s_d = ov_d ? {a_d[L][WIDTH-1], {(WIDTH-1){~a_d[L][WIDTH-1]}}} : r_d[L];
`else
    s_d = r_d[L];
`endif
  end
  // Data registers load only on valid stages so bubbles leave the held result untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        r_q[k] <= '0;
      end
      for (int k = 0; k < NP; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ov_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          c_q[k] <= c_d[k];
          r_q[k] <= (k == L) ? s_d : r_d[k];
        end
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
        end
      end
      if (v_d[L]) ov_q <= ov_d;
    end
  end
  always_comb begin
    in_ready  = en;
    out_valid = v_q[L];
    sum       = r_q[L];
    cout      = c_q[L];
    overflow  = ov_q;
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors with a queue scoreboard for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        ov;
  } vec_t;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        ov;
  } exp_t;
`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [31:0] S1 = 32'h7FFFFFFF, S5 = 32'h80000000, S6 = 32'h80000000;
`else
  localparam logic [31:0] S1 = 32'h80000000, S5 = 32'h00000000, S6 = 32'h7FFFFFFF;
`endif
  logic        clk = 0, rst_n = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic        in_ready, out_valid, cout, overflow;
  logic [31:0] sum;
  vec_t        vecs [11];
  exp_t        q [$];
  exp_t        e, hd;
  int          errors = 0, checks = 0, n_out = 0, lat, run, g;
  bit          mon_en = 1;
  always #5 clk = ~clk;
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input int i, input bit push);
    bit   done;
    int   guard;
    exp_t x;
    done = 0;
    guard = 0;
    in_valid = 1;
    a = vecs[i].a;
    b = vecs[i].b;
    cin = vecs[i].cin;
    sub = vecs[i].sub;
    while (!done && guard < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: vector %0d never accepted", i);
    end else if (push) begin
      x.s = vecs[i].s;
      x.c = vecs[i].c;
      x.ov = vecs[i].ov;
      q.push_back(x);
    end
    in_valid = 0;
  endtask
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: sum=%0h with empty scoreboard", sum);
      end else begin
        e = q.pop_front();
        chk("result", {sum, cout, overflow}, {e.s, e.c, e.ov});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end
  initial begin
    vecs[0]  = {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = {32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, S1,           1'b0, 1'b1};
    vecs[2]  = {32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3]  = {32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[4]  = {32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0};
    vecs[5]  = {32'h80000000, 32'h80000000, 1'b0, 1'b0, S5,           1'b1, 1'b1};
    vecs[6]  = {32'h80000000, 32'h00000001, 1'b0, 1'b1, S6,           1'b1, 1'b1};
    vecs[7]  = {32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, 32'h12355677, 1'b0, 1'b0};
    vecs[8]  = {32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = {32'h00010000, 32'h00000001, 1'b1, 1'b1, 32'h0000FFFF, 1'b1, 1'b0};
    vecs[10] = {32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    issue(0, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
    repeat (3) @(posedge clk);
    #1;
    fork
      for (int i = 1; i <= 8; i++) issue(i, 1);
      begin
        g = 0;
        run = 0;
        while (!out_valid && g < 30) begin
          @(negedge clk);
          g++;
        end
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
        chk("b2b_run", run, 8);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 11; i++) issue(i, 1);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_pre_valid", out_valid, 1);
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stall_hold: scoreboard empty during stall");
          end else begin
            hd = q[0];
            chk("stall_hold", {sum, cout, overflow}, {hd.s, hd.c, hd.ov});
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("drain_queue", q.size(), 0);
    chk("total_results", n_out, 20);
    mon_en = 0;
    for (int i = 0; i < 4; i++) issue(i, 0);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_ready", in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    q.delete();
    n_out = 0;
    mon_en = 1;
    issue(7, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_count", n_out, 1);
    chk("post_rst_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
